// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 codes, FSM states,
// response error codes and the request classifier.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_MIS = 2'd1;
  localparam logic [1:0] ERR_OOR = 2'd2;
  localparam logic [1:0] ERR_ILL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Priority illegal > misaligned > out-of-range. The range test uses the full
  // 30-bit word index so high addresses can never alias into the memory.
  function automatic logic [1:0] lsu_classify(input logic        we,
                                              input logic [2:0]  funct3,
                                              input logic [31:0] addr,
                                              input int          addr_words);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (we) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else    illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                   (funct3 == F3_W && addr[1:0] != 2'b00);
    out_of_range = {2'b00, addr[31:2]} >= $unsigned(addr_words);
    if (illegal)           return ERR_ILL;
    else if (misaligned)   return ERR_MIS;
    else if (out_of_range) return ERR_OOR;
    else                   return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational byte-lane logic: load lane select/extension and the
// read-modify-write merge for sub-word stores.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave a value held (a latch).
  always_comb begin
    shifted   = word >> {byte_off, 3'b000};
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = word;
    endcase

    store_word = wdata;
    case (funct3)
      F3_B: begin
        store_word = word;
        store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        store_word = word;
        store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// MEM-stage load/store initiator: one request per handshake, word-indexed
// data memory access with read-modify-write for byte/half stores.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WORDS = 64,
  parameter int IDX_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [1:0]        err_q;
  logic [1:0]        req_err;
  logic              accept;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign req_err = lsu_classify(req_we, req_funct3, req_addr, ADDR_WORDS);
  assign accept  = (state_q == S_IDLE) && req_valid;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      idx_q    <= '0;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
      err_q    <= ERR_OK;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        idx_q    <= req_addr[IDX_W+1:2];
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata;
        word_q   <= 32'h0;
        err_q    <= req_err;
      end else if (state_q == S_RD) begin
        word_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err != ERR_OK)                     state_d = S_RESP;
          else if (!req_we || req_funct3 != F3_W)    state_d = S_RD;
          else                                       state_d = S_WR;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  lsu_lane_unit u_lane (
    .word       (word_q),
    .wdata      (wdata_q),
    .byte_off   (off_q),
    .funct3     (funct3_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Outputs are gated by reset so they drop in the reset cycle itself, not
  // one edge later when the state register clears.
  always_comb begin
    req_ready = (state_q == S_IDLE) && !reset;
    busy      = !req_ready && !reset;
    mem_read  = (state_q == S_RD) && !reset;
    mem_write = (state_q == S_WR) && !reset;
    mem_addr  = (mem_read || mem_write) ? 32'(idx_q) : 32'h0;
    mem_wdata = mem_write ? store_word : 32'h0;
    rsp_valid = (state_q == S_RESP) && !reset;
    rsp_err   = rsp_valid ? err_q : ERR_OK;
    rsp_rdata = (rsp_valid && !we_q && err_q == ERR_OK) ? load_data : 32'h0;
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Self-checking bench for lsu_dmem_master: vector table through a response
// scoreboard, plus backpressure and mid-operation reset sequences.
module tb_lsu_dmem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_dmem_master #(.ADDR_WORDS(64), .IDX_W(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural data memory: combinational read, posedge write.
  logic [31:0] mem [64];
  assign mem_rdata = (mem_read && mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;
  always @(posedge clk)
    if (mem_write && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [1:0] err, input int lat, input int rd, input int wr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    e.rdata = v.exp_rdata; e.err = v.exp_err;
    e.lat = v.exp_lat; e.rd = v.exp_rd; e.wr = v.exp_wr;
    sb_q.push_back(e);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // One request from accept to response handshake, with per-cycle bus checks.
  task automatic run_txn(input vec_t v, input string tag);
    int   rd, wr, lat;
    logic got;
    exp_t e;
    rd = 0; wr = 0; lat = 0; got = 1'b0;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    drive(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      lat = c;
      if (mem_read)  rd++;
      if (mem_write) wr++;
      check({tag, "_rd_wr_excl"}, 32'(mem_read & mem_write), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'(!req_ready));
      if (mem_read || mem_write) check({tag, "_mem_addr"}, mem_addr, v.addr >> 2);
      else                       check({tag, "_idle_bus"}, mem_addr | mem_wdata, 32'h0);
      if (rsp_valid) got = 1'b1;
    end
    e = sb_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
      check({tag, "_rd_pulses"}, 32'(rd), 32'(e.rd));
      check({tag, "_wr_pulses"}, 32'(wr), 32'(e.wr));
    end
    ack_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic got;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

    // {we, funct3, addr, wdata, rdata, err, latency, read pulses, write pulses}
    vecs.push_back(mk(1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        ERR_OK, 2, 0, 1));
    vecs.push_back(mk(0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(0, F3_B,  32'h11, 32'h0,        32'hFFFFFFBE, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(0, F3_BU, 32'h11, 32'h0,        32'h000000BE, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(0, F3_HU, 32'h12, 32'h0,        32'h0000DEAD, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(1, F3_B,  32'h11, 32'h000000AA, 32'h0,        ERR_OK, 3, 1, 1));
    vecs.push_back(mk(0, F3_W,  32'h10, 32'h0,        32'hDEADAAEF, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(1, F3_H,  32'h12, 32'hFFFF1234, 32'h0,        ERR_OK, 3, 1, 1));
    vecs.push_back(mk(0, F3_W,  32'h10, 32'h0,        32'h1234AAEF, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(0, F3_B,  32'h13, 32'h0,        32'h00000012, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(0, F3_H,  32'h10, 32'h0,        32'hFFFFAAEF, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(0, F3_B,  32'h10, 32'h0,        32'hFFFFFFEF, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(0, F3_W,  32'hFC, 32'h0,        32'hC0DE003F, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(1, F3_B,  32'hFF, 32'h00000080, 32'h0,        ERR_OK, 3, 1, 1));
    vecs.push_back(mk(0, F3_BU, 32'hFF, 32'h0,        32'h00000080, ERR_OK, 2, 1, 0));
    vecs.push_back(mk(0, F3_W,  32'h13, 32'h0,        32'h0, ERR_MIS, 1, 0, 0));
    vecs.push_back(mk(1, F3_W,  32'h100, 32'h5,       32'h0, ERR_OOR, 1, 0, 0));
    vecs.push_back(mk(0, 3'b011, 32'h10, 32'h0,       32'h0, ERR_ILL, 1, 0, 0));
    vecs.push_back(mk(1, F3_H,  32'h101, 32'h7,       32'h0, ERR_MIS, 1, 0, 0));
    vecs.push_back(mk(1, F3_BU, 32'h10, 32'h9,        32'h0, ERR_ILL, 1, 0, 0));
    vecs.push_back(mk(0, F3_HU, 32'h11, 32'h0,        32'h0, ERR_MIS, 1, 0, 0));
    vecs.push_back(mk(1, F3_W,  32'h12, 32'h3,        32'h0, ERR_MIS, 1, 0, 0));
    vecs.push_back(mk(0, F3_W,  32'hFFFFFFFC, 32'h0,  32'h0, ERR_OOR, 1, 0, 0));
    vecs.push_back(mk(1, F3_W,  32'h1000, 32'h11,     32'h0, ERR_OOR, 1, 0, 0));
    vecs.push_back(mk(0, 3'b111, 32'h103, 32'h0,      32'h0, ERR_ILL, 1, 0, 0));

    // Reset state: everything low while reset is held, ready right after.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_outputs", 32'({rsp_valid, busy, mem_read, mem_write}), 32'd0);
    check("rst_buses", mem_addr | mem_wdata | rsp_rdata | 32'(rsp_err), 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    check("mem_word4", mem[4], 32'h1234AAEF);
    check("mem_word63", mem[63], 32'h80DE003F);
    check("mem_word0_untouched", mem[0], 32'hC0DE0000);
    check("mem_word5_untouched", mem[5], 32'hC0DE0005);

    // Backpressure: response held 5 cycles while a new request waits.
    @(negedge clk);
    drive(mk(0, F3_W, 32'h10, 32'h0, 32'h1234AAEF, ERR_OK, 2, 1, 0));
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("bp_rsp_seen", 32'(got), 32'd1);
    drive(mk(0, F3_W, 32'h20, 32'h0, 32'hC0DE0008, ERR_OK, 2, 1, 0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
      check("bp_rdata_held", rsp_rdata, 32'h1234AAEF);
      check("bp_req_ready_low", 32'(req_ready), 32'd0);
      check("bp_no_mem_read", 32'(mem_read), 32'd0);
    end
    e = sb_q.pop_front();
    check("bp_rdata", rsp_rdata, e.rdata);
    check("bp_err", 32'(rsp_err), 32'(e.err));
    ack_rsp();
    @(negedge clk);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp_idle_no_read", 32'(mem_read), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_next_mem_read", 32'(mem_read), 32'd1);
    check("bp_next_mem_addr", mem_addr, 32'd8);
    @(negedge clk);
    e = sb_q.pop_front();
    check("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_next_rdata", rsp_rdata, e.rdata);
    ack_rsp();

    // Reset during the RD cycle of a byte store: the write must never happen.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_rd_cycle", 32'(mem_read), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_outputs_low", 32'({mem_read, mem_write, rsp_valid, req_ready}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("rstmid_no_write", 32'(mem_write), 32'd0);
      @(negedge clk);
    end
    check("rstmid_word8", mem[8], 32'hC0DE0008);

    run_txn(mk(0, F3_W, 32'h20, 32'h0, 32'hC0DE0008, ERR_OK, 2, 1, 0), "post_rstmid_lw");
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
